// File: rtl/reset_sequencer.sv
// Reset sequencer: asserts every reset output asynchronously, then releases
// them one at a time, in order, after a deassertion synchronizer and a hold
// interval. A synchronous software request re-runs the sequence without the
// synchronizer delay and answers with a one-cycle acknowledge.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int N_OUT       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_reset_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             ready,
  output logic             sw_ack
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced_ok;
  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;

  assign synced_ok = sync[SYNC_STAGES-1];

  // Deassertion synchronizer: fills with ones after reset, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Sequencing FSM: hold, staggered release, run; software request restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_ASSERT;
      rst_out <= '1;
      ready   <= 1'b0;
      sw_ack  <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
    end else begin
      sw_ack <= sw_reset_req;
      if (sw_reset_req) begin
        state   <= ST_ASSERT;
        rst_out <= '1;
        ready   <= 1'b0;
        cnt     <= '0;
        idx     <= '0;
      end else begin
        case (state)
          ST_ASSERT: begin
            rst_out <= '1;
            ready   <= 1'b0;
            if (synced_ok) begin
              if (cnt == HOLD_LAST) begin
                rst_out <= {N_OUT{1'b1}} << 1;
                cnt     <= '0;
                idx     <= IW'(1);
                if (N_OUT == 1) begin
                  ready <= 1'b1;
                  state <= ST_RUN;
                end else begin
                  state <= ST_RELEASE;
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          ST_RELEASE: begin
            if (cnt == GAP_LAST) begin
              // Released bits are always the low ones, so clearing rst_out[idx]
              // is the same as shifting a zero in from the bottom.
              rst_out <= rst_out << 1;
              cnt     <= '0;
              idx     <= idx + IW'(1);
              if (idx == IDX_LAST) begin
                ready <= 1'b1;
                state <= ST_RUN;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_RUN: begin
            rst_out <= '0;
            ready   <= 1'b1;
          end
          default: begin
            state   <= ST_ASSERT;
            rst_out <= '1;
            ready   <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
          end
        endcase
      end
    end
  end

endmodule
